// File: rtl/prog_mem_pkg.sv
// Shared constants and types for the program memory arbiter.
// Latency: none (declarations only). Backpressure: not applicable.
// Window defaults, FSM state codes and requester identifiers.
package prog_mem_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h31B0;
    localparam int unsigned DEF_WINDOW    = 1024;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_id_t;

endpackage

// File: rtl/prog_addr_window.sv
// Logical-to-physical translation with an unsigned range check against the window.
// Latency: combinational. Backpressure: none.
// The sum wraps silently; only the in-range flag decides whether it is used.
module prog_addr_window
    import prog_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WINDOW    = DEF_WINDOW
) (
    input  logic [31:0] i_addr,
    output logic        o_in_range,
    output logic [31:0] o_phys
);

    assign o_in_range = (i_addr < WINDOW);
    assign o_phys     = i_addr + BASE_ADDR;

endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares the program memory between fetch and loader: round-robin grant, window check, cs_n sequencing.
// Latency: grant at edge N, response at edge N+MEM_LAT (N+1 for an out-of-window address).
// Backpressure: requesters hold req until gnt; one access in flight, requests ignored while busy.
module prog_mem_arbiter
    import prog_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_gnt,
    output logic        o_f_rvalid,
    output logic [31:0] o_f_rdata,
    output logic        o_f_err,
    input  logic        i_l_req,
    input  logic        i_l_we,
    input  logic [31:0] i_l_addr,
    input  logic [31:0] i_l_wdata,
    output logic        o_l_gnt,
    output logic        o_l_done,
    output logic [31:0] o_l_rdata,
    output logic        o_l_err,
    output logic        o_mem_cs_n,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    logic [1:0]  r_state;
    req_id_t     r_prio;
    req_id_t     r_owner;
    logic [2:0]  r_cnt;
    logic        r_f_gnt, r_f_rvalid, r_f_err;
    logic        r_l_gnt, r_l_done, r_l_err;
    logic [31:0] r_f_rdata, r_l_rdata;
    logic        r_mem_cs_n, r_mem_we, r_busy;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic        w_f_win, w_l_win, w_sel_we, w_in_range;
    logic [31:0] w_sel_addr, w_phys, w_rdata;

    // Fetch wins when alone or when it holds priority; loader takes whatever is left.
    assign w_f_win    = i_f_req & (~i_l_req | (r_prio == REQ_FETCH));
    assign w_l_win    = i_l_req & ~w_f_win;
    assign w_sel_addr = w_l_win ? i_l_addr : i_f_addr;
    assign w_sel_we   = w_l_win & i_l_we;
    assign w_rdata    = r_mem_we ? 32'd0 : i_mem_rdata;

    prog_addr_window #(
        .BASE_ADDR (BASE_ADDR),
        .WINDOW    (WINDOW)
    ) u_window (
        .i_addr     (w_sel_addr),
        .o_in_range (w_in_range),
        .o_phys     (w_phys)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_prio      <= REQ_FETCH;
            r_owner     <= REQ_FETCH;
            r_cnt       <= 3'd0;
            r_f_gnt     <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_f_rdata   <= 32'd0;
            r_f_err     <= 1'b0;
            r_l_gnt     <= 1'b0;
            r_l_done    <= 1'b0;
            r_l_rdata   <= 32'd0;
            r_l_err     <= 1'b0;
            r_mem_cs_n  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_f_gnt    <= 1'b0;
            r_l_gnt    <= 1'b0;
            r_f_rvalid <= 1'b0;
            r_l_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_f_win | w_l_win) begin
                        r_f_gnt <= w_f_win;
                        r_l_gnt <= w_l_win;
                        r_owner <= w_l_win ? REQ_LOAD : REQ_FETCH;
                        r_prio  <= w_l_win ? REQ_FETCH : REQ_LOAD;
                        r_busy  <= 1'b1;
                        if (w_in_range) begin
                            r_mem_cs_n  <= 1'b0;
                            r_mem_we    <= w_sel_we;
                            r_mem_addr  <= w_phys;
                            r_mem_wdata <= w_l_win ? i_l_wdata : 32'd0;
                            r_cnt       <= 3'(MEM_LAT - 1);
                            r_state     <= ST_ACCESS;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        if (r_owner == REQ_LOAD) begin
                            r_l_done  <= 1'b1;
                            r_l_rdata <= w_rdata;
                            r_l_err   <= 1'b0;
                        end else begin
                            r_f_rvalid <= 1'b1;
                            r_f_rdata  <= w_rdata;
                            r_f_err    <= 1'b0;
                        end
                        r_mem_cs_n  <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_wdata <= 32'd0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (r_owner == REQ_LOAD) begin
                        r_l_done  <= 1'b1;
                        r_l_rdata <= 32'd0;
                        r_l_err   <= 1'b1;
                    end else begin
                        r_f_rvalid <= 1'b1;
                        r_f_rdata  <= 32'd0;
                        r_f_err    <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_f_gnt     = r_f_gnt;
    assign o_f_rvalid  = r_f_rvalid;
    assign o_f_rdata   = r_f_rdata;
    assign o_f_err     = r_f_err;
    assign o_l_gnt     = r_l_gnt;
    assign o_l_done    = r_l_done;
    assign o_l_rdata   = r_l_rdata;
    assign o_l_err     = r_l_err;
    assign o_mem_cs_n  = r_mem_cs_n;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Two arbiter instances (memory latency 1 and 3) driven with directed then random traffic.
// Expected responses are queued at grant time and checked by a per-instance monitor.
module tb_prog_mem_arbiter;

    localparam logic [31:0] BASE      = 32'h31B0;
    localparam int          NDIR      = 12;
    localparam int          NRAND     = 250;
    localparam int          GNT_BOUND = 40;

    typedef struct {
        logic        is_l;
        logic        err;
        logic        we;
        logic [31:0] data;
        logic [31:0] phys;
        logic [31:0] wdata;
        int          gcyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        f_on;
        logic [31:0] f_addr;
        logic        l_on;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic rst_go;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %h, expected %h", name, ln, act, exp);
        end
    endtask

    task automatic fail(input string name, input int ln);
        vectors++;
        miscompares++;
        $display("FAIL %s lane%0d: awaited event not seen within bound", name, ln);
    endtask

    // Memory background content for never-written words.
    function automatic logic [31:0] bg(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1023;
            2:       return 32'd1024;
            3:       return 32'hFFFF_FFFF;
            4:       return $urandom;
            default: return 32'($urandom_range(0, 1023));
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        f_req, l_req, l_we;
        logic [31:0] f_addr, l_addr, l_wdata, mem_rdata;
        logic        f_gnt, f_rvalid, f_err, l_gnt, l_done, l_err, mem_cs_n, mem_we, busy;
        logic [31:0] f_rdata, l_rdata, mem_addr, mem_wdata;
        logic        done, rst_req;
        exp_t        q[$];
        logic [31:0] phys_mem [logic [31:0]];
        int          lowcnt = 0;
        int          busycnt = 0;

        prog_mem_arbiter #(
            .BASE_ADDR (BASE),
            .WINDOW    (1024),
            .MEM_LAT   (LAT)
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_f_req     (f_req),
            .i_f_addr    (f_addr),
            .o_f_gnt     (f_gnt),
            .o_f_rvalid  (f_rvalid),
            .o_f_rdata   (f_rdata),
            .o_f_err     (f_err),
            .i_l_req     (l_req),
            .i_l_we      (l_we),
            .i_l_addr    (l_addr),
            .i_l_wdata   (l_wdata),
            .o_l_gnt     (l_gnt),
            .o_l_done    (l_done),
            .o_l_rdata   (l_rdata),
            .o_l_err     (l_err),
            .o_mem_cs_n  (mem_cs_n),
            .o_mem_we    (mem_we),
            .o_mem_addr  (mem_addr),
            .o_mem_wdata (mem_wdata),
            .i_mem_rdata (mem_rdata),
            .o_busy      (busy)
        );

        task automatic chk_rst(input string tag);
            check({tag, "_ctrl"}, g, {23'd0, f_gnt, f_rvalid, f_err, l_gnt, l_done, l_err,
                                      mem_cs_n, mem_we, busy}, 32'h0000_0004);
            check({tag, "_f_rdata"}, g, f_rdata, 32'd0);
            check({tag, "_l_rdata"}, g, l_rdata, 32'd0);
            check({tag, "_mem_addr"}, g, mem_addr, 32'd0);
            check({tag, "_mem_wdata"}, g, mem_wdata, 32'd0);
        endtask

        // Memory slave plus monitor: data is only valid once cs_n has been low LAT cycles.
        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_n) begin
                q.delete();
                lowcnt  = 0;
                busycnt = 0;
            end else begin
                if (!mem_cs_n) begin
                    lowcnt++;
                    if (lowcnt == 1) begin
                        if (q.size() == 0 || q[0].err) begin
                            fail("cs_without_access", g);
                        end else begin
                            check("mem_addr", g, mem_addr, q[0].phys);
                            check("mem_we", g, mem_we, q[0].we);
                            if (q[0].we) check("mem_wdata", g, mem_wdata, q[0].wdata);
                        end
                    end
                    if (mem_we) phys_mem[mem_addr] = mem_wdata;
                end else if (lowcnt != 0) begin
                    check("cs_low_cycles", g, lowcnt, LAT);
                    check("mem_addr_idle", g, mem_addr, 32'd0);
                    lowcnt = 0;
                end
                if (f_rvalid || l_done) begin
                    if (q.size() == 0) begin
                        fail("unexpected_resp", g);
                    end else begin
                        e = q.pop_front();
                        check("resp_side", g, l_done, e.is_l);
                        check("rdata", g, e.is_l ? l_rdata : f_rdata, e.data);
                        check("err", g, e.is_l ? l_err : f_err, e.err);
                        check("latency", g, cyc - e.gcyc, e.lat);
                        check("busy_cycles", g, busycnt, e.lat);
                    end
                    busycnt = 0;
                end
                if (busy) busycnt++;
            end
            if (!mem_cs_n && !mem_we && lowcnt >= LAT)
                mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : bg(mem_addr);
            else
                mem_rdata = $urandom;
        end

        initial begin : drv
            logic [31:0] ref_mem [0:1023];
            stim_t       dir [NDIR];
            stim_t       s;
            exp_t        e;
            logic        prio_l;
            logic        exp_l;
            logic [31:0] a;
            int          k;

            f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
            f_addr = 32'd0; l_addr = 32'd0; l_wdata = 32'd0;
            done = 1'b0; rst_req = 1'b0;
            prio_l = 1'b0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = bg(BASE + 32'(i));

            dir[0] = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd0,    32'hDEADBEEF};
            dir[1] = '{1'b1, 32'd0,          1'b0, 1'b0, 32'd0,    32'd0};
            dir[2] = '{1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0,    32'd0};
            dir[3] = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd1023, 32'h12345678};
            dir[4] = '{1'b0, 32'd0,          1'b1, 1'b0, 32'd1023, 32'd0};
            dir[5] = '{1'b0, 32'd0,          1'b1, 1'b0, 32'd1024, 32'd0};
            for (int i = 6; i < NDIR; i++)
                dir[i] = '{1'b1, 32'($urandom_range(0, 1023)), 1'b1, 1'($urandom_range(0, 1)),
                           32'($urandom_range(0, 1023)), $urandom};

            repeat (2) @(posedge clk);
            #1;
            chk_rst("reset");
            wait (start);
            @(posedge clk);
            #1;

            for (int i = 0; i < NDIR + NRAND; i++) begin
                if (i < NDIR) begin
                    s = dir[i];
                end else begin
                    s.f_on    = ($urandom_range(0, 3) != 0);
                    s.f_addr  = pick_addr();
                    s.l_on    = ($urandom_range(0, 2) != 0);
                    s.l_we    = 1'($urandom_range(0, 1));
                    s.l_addr  = pick_addr();
                    s.l_wdata = $urandom;
                end
                if (!f_req && s.f_on) begin
                    f_req = 1'b1; f_addr = s.f_addr;
                end
                if (!l_req && s.l_on) begin
                    l_req = 1'b1; l_we = s.l_we; l_addr = s.l_addr; l_wdata = s.l_wdata;
                end
                if (!f_req && !l_req) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    continue;
                end

                // Round robin: a lone requester wins, otherwise the side holding priority.
                exp_l = l_req && (!f_req || prio_l);
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!(f_gnt || l_gnt) && k < GNT_BOUND);
                if (!(f_gnt || l_gnt)) begin
                    fail("gnt_timeout", g);
                    f_req = 1'b0; l_req = 1'b0;
                    continue;
                end
                check("gnt_side", g, l_gnt, exp_l);
                check("gnt_onehot", g, f_gnt & l_gnt, 1'b0);

                a       = exp_l ? l_addr : f_addr;
                e.is_l  = exp_l;
                e.we    = exp_l & l_we;
                e.wdata = l_wdata;
                e.gcyc  = cyc;
                if (a < 32'd1024) begin
                    e.err  = 1'b0;
                    e.phys = a + BASE;
                    e.data = e.we ? 32'd0 : ref_mem[a[9:0]];
                    if (e.we) ref_mem[a[9:0]] = l_wdata;
                    e.lat  = LAT;
                end else begin
                    e.err  = 1'b1;
                    e.phys = 32'd0;
                    e.data = 32'd0;
                    e.lat  = 1;
                end
                q.push_back(e);
                prio_l = !exp_l;
                if (exp_l) l_req = 1'b0;
                else       f_req = 1'b0;
            end

            f_req = 1'b0; l_req = 1'b0;
            repeat (6) @(posedge clk);
            #1;

            // Slow instance: start a fetch, then have the reset land while it is in flight.
            if (g == 1) begin
                k = 0;
                while (!rst_go && k < 20000) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                f_req = 1'b1; f_addr = 32'd5;
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!f_gnt && k < GNT_BOUND);
                if (!f_gnt) begin
                    fail("rst_gnt_timeout", g);
                end else begin
                    e.is_l = 1'b0; e.err = 1'b0; e.we = 1'b0; e.wdata = 32'd0;
                    e.phys = BASE + 32'd5; e.data = ref_mem[5]; e.gcyc = cyc; e.lat = LAT;
                    q.push_back(e);
                end
                f_req = 1'b0;
                @(posedge clk);
                #1;
                check("busy_pre_reset", g, busy, 1'b1);
                rst_req = 1'b1;
                k = 0;
                while (rst_n && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                if (rst_n) begin
                    fail("reset_not_seen", g);
                end else begin
                    #1;
                    chk_rst("midrst");
                end
                k = 0;
                while (!rst_n && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                k = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (f_rvalid || l_done) k++;
                end
                check("resp_after_reset", g, k, 0);
            end
            done = 1'b1;
        end
    end

    initial begin : main_seq
        int k;
        rst_n = 1'b0; start = 1'b0; rst_go = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;

        k = 0;
        while (!lane[0].done && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!lane[0].done) fail("lane_done", 0);
        check("drained", 0, lane[0].q.size(), 0);
        rst_go = 1'b1;

        k = 0;
        while (!lane[1].rst_req && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!lane[1].rst_req) begin
            fail("rst_request", 1);
        end else begin
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end

        k = 0;
        while (!lane[1].done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!lane[1].done) fail("lane_done", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
